// File: rtl/vnu_serial_if.sv
// rtl/vnu_serial_if.sv - message stream interface between the layered decoder and the VNU
interface vnu_serial_if #(
  parameter int VN_DEGREE = 3,
  parameter int QUAN_SIZE = 4
);
  localparam int IDX_W = (VN_DEGREE > 1) ? $clog2(VN_DEGREE) : 1;

  logic [QUAN_SIZE-1:0] in_msg;
  logic                 in_valid;
  logic                 in_ready;
  logic [QUAN_SIZE-1:0] v2c_msg;
  logic [IDX_W-1:0]     v2c_idx;
  logic                 v2c_valid;
  logic                 v2c_last;
  logic                 v2c_ready;
  logic                 hard_dec;
  logic                 hard_dec_valid;

  modport slave (
    input  in_msg, in_valid, v2c_ready,
    output in_ready, v2c_msg, v2c_idx, v2c_valid, v2c_last, hard_dec, hard_dec_valid
  );

  modport master (
    output in_msg, in_valid, v2c_ready,
    input  in_ready, v2c_msg, v2c_idx, v2c_valid, v2c_last, hard_dec, hard_dec_valid
  );
endinterface

// File: rtl/vnu_serial.sv
// rtl/vnu_serial.sv - serial variable-node update: accumulates ch + c2v beats, emits extrinsic v2c
module vnu_serial #(
  parameter int VN_DEGREE = 3,
  parameter int QUAN_SIZE = 4,
  parameter int MAG_SIZE  = QUAN_SIZE - 1,
  parameter int SUM_SIZE  = 6
) (
  input logic        sys_clk,
  input logic        rst,
  vnu_serial_if.slave bus
);
  localparam int IDX_W = (VN_DEGREE > 1) ? $clog2(VN_DEGREE) : 1;
  localparam int CNT_W = $clog2(VN_DEGREE + 1);
  localparam logic [MAG_SIZE-1:0] MAG_MAX = '1;
  localparam logic signed [SUM_SIZE:0] SAT_P = $signed({{(SUM_SIZE + 1 - MAG_SIZE){1'b0}}, MAG_MAX});
  localparam logic signed [SUM_SIZE:0] SAT_N = -SAT_P;

  typedef enum logic {LOAD, EMIT} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           beat_cnt;
  logic [IDX_W-1:0]           edge_idx;
  logic signed [SUM_SIZE-1:0] acc, acc_nxt, beat_val, edge_c2v;
  logic signed [SUM_SIZE-1:0] c2v_buf [VN_DEGREE];
  logic signed [SUM_SIZE:0]   diff;
  logic                       in_fire, v2c_fire, last_beat, last_edge;
  logic                       hard_dec_q, hard_dec_valid_q;

  // Negative zero falls out as zero because the negated magnitude is zero.
  function automatic logic signed [SUM_SIZE-1:0] sm_to_tc(input logic [QUAN_SIZE-1:0] m);
    logic signed [SUM_SIZE-1:0] mag;
    mag = $signed({{(SUM_SIZE - MAG_SIZE){1'b0}}, m[MAG_SIZE-1:0]});
    return m[QUAN_SIZE-1] ? -mag : mag;
  endfunction

  function automatic logic [QUAN_SIZE-1:0] tc_to_sm(input logic signed [SUM_SIZE:0] v);
    logic [SUM_SIZE:0] neg;
    neg = -v;
    if (v > SAT_P) return {1'b0, MAG_MAX};
    if (v < SAT_N) return {1'b1, MAG_MAX};
    if (v[SUM_SIZE]) return {1'b1, neg[MAG_SIZE-1:0]};
    return {1'b0, v[MAG_SIZE-1:0]};
  endfunction

  assign beat_val  = sm_to_tc(bus.in_msg);
  assign acc_nxt   = acc + beat_val;
  assign last_beat = (beat_cnt == CNT_W'(VN_DEGREE));
  assign last_edge = (edge_idx == IDX_W'(VN_DEGREE - 1));
  assign in_fire   = (state == LOAD) && !rst && bus.in_valid;
  assign v2c_fire  = (state == EMIT) && !rst && bus.v2c_ready;

  always_comb begin
    edge_c2v = '0;
    for (int i = 0; i < VN_DEGREE; i++) begin
      if (edge_idx == IDX_W'(i)) edge_c2v = c2v_buf[i];
    end
  end

  assign diff = {acc[SUM_SIZE-1], acc} - {edge_c2v[SUM_SIZE-1], edge_c2v};

  always_ff @(posedge sys_clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.in_ready   = 1'b0;
    bus.v2c_valid  = 1'b0;
    bus.v2c_msg    = '0;
    bus.v2c_idx    = '0;
    bus.v2c_last   = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = !rst;
        if (in_fire && last_beat) state_nxt = EMIT;
      end
      EMIT: begin
        bus.v2c_valid = !rst;
        bus.v2c_msg   = tc_to_sm(diff);
        bus.v2c_idx   = edge_idx;
        bus.v2c_last  = last_edge;
        if (v2c_fire && last_edge) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      acc              <= '0;
      beat_cnt         <= '0;
      edge_idx         <= '0;
      hard_dec_q       <= 1'b0;
      hard_dec_valid_q <= 1'b0;
      for (int i = 0; i < VN_DEGREE; i++) c2v_buf[i] <= '0;
    end else begin
      hard_dec_valid_q <= 1'b0;
      if (in_fire) begin
        acc      <= acc_nxt;
        beat_cnt <= beat_cnt + 1'b1;
        for (int i = 0; i < VN_DEGREE; i++) begin
          if (beat_cnt == CNT_W'(i + 1)) c2v_buf[i] <= beat_val;
        end
        // The decision is latched from the final total so it stays valid while the next frame loads.
        if (last_beat) begin
          hard_dec_q       <= acc_nxt[SUM_SIZE-1];
          hard_dec_valid_q <= 1'b1;
        end
      end
      if (v2c_fire) begin
        if (last_edge) begin
          edge_idx <= '0;
          acc      <= '0;
          beat_cnt <= '0;
        end else begin
          edge_idx <= edge_idx + 1'b1;
        end
      end
    end
  end

  assign bus.hard_dec       = hard_dec_q;
  assign bus.hard_dec_valid = hard_dec_valid_q;
endmodule

// File: tb/tb_vnu_serial.sv
// tb/tb_vnu_serial.sv - scoreboard bench for vnu_serial with directed and random frames
module tb_vnu_serial;
  localparam int VN = 3;
  localparam int Q  = 4;

  typedef struct packed {
    logic [3:0] msg;
    logic [1:0] idx;
    logic       last;
  } v2c_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vnu_serial_if #(.VN_DEGREE(VN), .QUAN_SIZE(Q)) bus ();

  vnu_serial #(.VN_DEGREE(VN), .QUAN_SIZE(Q), .MAG_SIZE(Q - 1), .SUM_SIZE(6)) dut (
    .sys_clk(clk),
    .rst    (rst),
    .bus    (bus)
  );

  v2c_t exp_q[$];
  logic hd_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  logic cur_hd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  function automatic int sm2int(input logic [3:0] m);
    return m[3] ? -int'(m[2:0]) : int'(m[2:0]);
  endfunction

  function automatic logic [3:0] int2sm(input int v);
    int s;
    s = v;
    if (s > 7) s = 7;
    if (s < -7) s = -7;
    if (s < 0) return {1'b1, 3'(-s)};
    return {1'b0, 3'(s)};
  endfunction

  task automatic push_model(input logic [3:0] b[4]);
    int total;
    total = 0;
    for (int i = 0; i < 4; i++) total += sm2int(b[i]);
    for (int k = 0; k < VN; k++) exp_q.push_back('{int2sm(total - sm2int(b[k + 1])), 2'(k), k == VN - 1});
    hd_q.push_back(total < 0);
  endtask

  task automatic push_direct(input logic [3:0] e[3], input logic hd);
    for (int k = 0; k < VN; k++) exp_q.push_back('{e[k], 2'(k), k == VN - 1});
    hd_q.push_back(hd);
  endtask

  task automatic send_frame(input logic [3:0] b[4], input int gap);
    logic got;
    for (int i = 0; i < 4; i++) begin
      bus.in_msg   = b[i];
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) fail_now("in_ready_timeout");
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    check("first_v2c_valid", 32'(bus.v2c_valid), 32'(1));
    check("first_hard_dec_valid", 32'(bus.hard_dec_valid), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    bus.v2c_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.v2c_ready = 1'b1;
        1:       bus.v2c_ready = 1'($urandom_range(0, 1));
        default: bus.v2c_ready = 1'b0;
      endcase
    end
  end

  initial begin
    v2c_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.hard_dec_valid) begin
          check("hdv_align", 32'(bus.v2c_valid && bus.v2c_idx == 2'd0), 32'(1));
          if (hd_q.size() == 0) fail_now("hard_dec_unexpected");
          else begin
            cur_hd = hd_q.pop_front();
            check("hard_dec", 32'(bus.hard_dec), 32'(cur_hd));
          end
        end
        if (bus.v2c_valid) check("hard_dec_hold", 32'(bus.hard_dec), 32'(cur_hd));
        if (bus.v2c_valid && bus.v2c_ready) begin
          if (exp_q.size() == 0) fail_now("v2c_unexpected");
          else begin
            e = exp_q.pop_front();
            check("v2c_msg", 32'(bus.v2c_msg), 32'(e.msg));
            check("v2c_idx", 32'(bus.v2c_idx), 32'(e.idx));
            check("v2c_last", 32'(bus.v2c_last), 32'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fb[4];
    logic [3:0] fe[3];

    bus.in_msg   = 4'b0111;
    bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'(0));
      check("rst_v2c_valid", 32'(bus.v2c_valid), 32'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_msg   = 4'b0000;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("post_rst_v2c_valid", 32'(bus.v2c_valid), 32'(0));
    check("post_rst_v2c_msg", 32'(bus.v2c_msg), 32'(0));
    check("post_rst_v2c_idx", 32'(bus.v2c_idx), 32'(0));
    check("post_rst_v2c_last", 32'(bus.v2c_last), 32'(0));
    check("post_rst_hard_dec", 32'(bus.hard_dec), 32'(0));
    check("post_rst_hdv", 32'(bus.hard_dec_valid), 32'(0));
    @(posedge clk); #1;

    fb = '{4'b0011, 4'b0001, 4'b0010, 4'b1001};
    fe = '{4'b0100, 4'b0011, 4'b0110};
    push_direct(fe, 1'b0); send_frame(fb, 0); drain();

    fb = '{4'b0111, 4'b0111, 4'b0111, 4'b0111};
    fe = '{4'b0111, 4'b0111, 4'b0111};
    push_direct(fe, 1'b0); send_frame(fb, 0); drain();

    fb = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
    fe = '{4'b1111, 4'b1111, 4'b1111};
    push_direct(fe, 1'b1); send_frame(fb, 0); drain();

    fb = '{4'b1000, 4'b1000, 4'b0001, 4'b1001};
    fe = '{4'b0000, 4'b1001, 4'b0001};
    push_direct(fe, 1'b0); send_frame(fb, 0); drain();

    fb = '{4'b0011, 4'b0001, 4'b0010, 4'b1001};
    fe = '{4'b0100, 4'b0011, 4'b0110};
    push_direct(fe, 1'b0); send_frame(fb, 2); drain();

    ready_mode = 2;
    push_direct(fe, 1'b0); send_frame(fb, 0);
    @(posedge clk); #1; ready_mode = 0;
    @(posedge clk); #1; ready_mode = 2;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.v2c_valid), 32'(1));
      check("bp_idx", 32'(bus.v2c_idx), 32'(1));
      check("bp_msg", 32'(bus.v2c_msg), 32'(4'b0011));
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    @(posedge clk); #1; ready_mode = 0;
    drain();

    ready_mode = 2;
    push_direct(fe, 1'b0); send_frame(fb, 0);
    @(posedge clk); #1; ready_mode = 0;
    @(posedge clk); #1; rst = 1'b1; ready_mode = 2;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_v2c_valid", 32'(bus.v2c_valid), 32'(0));
    check("abort_in_ready", 32'(bus.in_ready), 32'(1));
    check("abort_v2c_idx", 32'(bus.v2c_idx), 32'(0));
    check("abort_hdv", 32'(bus.hard_dec_valid), 32'(0));
    check("abort_remaining", 32'(exp_q.size()), 32'(2));
    exp_q.delete();
    hd_q.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    push_direct(fe, 1'b0); send_frame(fb, 0); drain();

    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) fb[i] = 4'($urandom_range(0, 15));
      push_model(fb);
      send_frame(fb, int'($urandom_range(0, 2)));
    end
    drain();
    check("hd_queue_empty", 32'(hd_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
